// File: rtl/sys_clken_pkg.sv
// Shared types and constants for the clock-enable generator.
package sys_clken_pkg;

  localparam int unsigned CH_W      = 3;
  localparam int unsigned DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    StAlign,
    StSettle,
    StLocked
  } state_e;

endpackage

// File: rtl/sys_clken_gen_if.sv
// Configuration request bus for sys_clken_gen.
interface sys_clken_gen_if
  import sys_clken_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/sys_clken_chan.sv
// One clock-enable channel: divide/phase registers, wrapping counter and strobe compare.
module sys_clken_chan #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             align_i,
  input  logic             active_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  output logic             en_o
);

  localparam logic [DIV_W-1:0] One      = DIV_W'(1);
  localparam logic [DIV_W-1:0] ResetDiv = (DEFAULT_DIV == 0) ? One : DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_eff;

  always_comb begin
    div_eff = (div_i == '0) ? One : div_i;
    div_d   = div_q;
    phase_d = phase_q;
    if (wr_i) begin
      div_d   = div_eff;
      // Out-of-range phase is clamped once here so the compare never misses.
      phase_d = (phase_i >= div_eff) ? (div_eff - One) : phase_i;
    end
    if (align_i || (cnt_q >= (div_q - One))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= ResetDiv;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign en_o = active_i && (cnt_q == phase_q);

endmodule

// File: rtl/sys_clken_gen.sv
// Multi-channel clock-enable generator with realign/settle/lock sequencing.
module sys_clken_gen
  import sys_clken_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = 1,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst,
  sys_clken_gen_if.slave    cfg,
  output logic [NUM_CH-1:0] en_out,
  output logic              locked
);

  localparam int unsigned     SetW    = $clog2(LOCK_CYCLES + 1);
  localparam logic [SetW-1:0] SetLast = SetW'(LOCK_CYCLES - 1);

  state_e          state_q, state_d;
  logic [SetW-1:0] settle_q, settle_d;
  logic            err_q, err_d;
  logic            active;
  logic            accept;
  logic            ch_ok;

  assign active = !rst && (state_q != StAlign);
  assign accept = cfg.cfg_valid && active;
  assign ch_ok  = 32'(cfg.cfg_ch) < NUM_CH;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    err_d    = accept && !ch_ok;
    unique case (state_q)
      StAlign: begin
        state_d  = StSettle;
        settle_d = '0;
      end
      StSettle: begin
        settle_d = settle_q + SetW'(1);
        if (settle_q == SetLast) begin
          state_d = StLocked;
        end
      end
      StLocked: ;
      default: state_d = StAlign;
    endcase
    // A valid request always realigns; a bad channel only raises cfg_err.
    if (accept && ch_ok) begin
      state_d = StAlign;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= StAlign;
      settle_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      err_q    <= err_d;
    end
  end

  assign cfg.cfg_ready = active;
  assign cfg.cfg_err   = err_q && !rst;
  assign locked        = !rst && (state_q == StLocked);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    sys_clken_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i    (refclk),
      .rst_i    (rst),
      .align_i  (state_q == StAlign),
      .active_i (active),
      .wr_i     (accept && ch_ok && (cfg.cfg_ch == CH_W'(i))),
      .div_i    (cfg.cfg_div),
      .phase_i  (cfg.cfg_phase),
      .en_o     (en_out[i])
    );
  end

endmodule

// File: tb/tb_sys_clken_gen.sv
// Directed bench for sys_clken_gen: reconfiguration table plus reset/error/settle sequences.
module tb_sys_clken_gen;

  logic       refclk;
  logic       rst;
  logic [1:0] en_out;
  logic       locked;
  int         tests;
  int         fails;

  sys_clken_gen_if #(.DIV_W(16)) cfg_if ();

  sys_clken_gen #(
    .NUM_CH      (2),
    .DIV_W       (16),
    .DEFAULT_DIV (1),
    .LOCK_CYCLES (16)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .cfg    (cfg_if.slave),
    .en_out (en_out),
    .locked (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] div;
    logic [15:0] phase;
    int          d0;
    int          p0;
    int          d1;
    int          p1;
  } rec_t;

  rec_t tbl [6];

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_en(input int k, input int d0, input int p0,
                                        input int d1, input int p1);
    return {((k % d1) == p1), ((k % d0) == p0)};
  endfunction

  task automatic drive(input logic v, input logic [2:0] ch, input logic [15:0] dv,
                       input logic [15:0] ph);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_div   = dv;
    cfg_if.cfg_phase = ph;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_en"}, 32'(en_out), 32'd0);
    chk({nm, "_locked"}, 32'(locked), 32'd0);
    chk({nm, "_ready"}, 32'(cfg_if.cfg_ready), 32'd0);
    chk({nm, "_err"}, 32'(cfg_if.cfg_err), 32'd0);
  endtask

  // Checks cycles k0..k0+n-1 of a settle/lock run, leaving the bench in cycle k0+n.
  task automatic run_k(input string nm, input int k0, input int n, input int d0, input int p0,
                       input int d1, input int p1);
    for (int k = k0; k < k0 + n; k++) begin
      chk({nm, "_en"}, 32'(en_out), 32'(exp_en(k, d0, p0, d1, p1)));
      chk({nm, "_locked"}, 32'(locked), 32'(k >= 16));
      chk({nm, "_ready"}, 32'(cfg_if.cfg_ready), 32'd1);
      step();
    end
  endtask

  // Accept in the current (locked) cycle, then check the single ALIGN cycle.
  task automatic reconfig(input string nm, input logic [2:0] ch, input logic [15:0] dv,
                          input logic [15:0] ph);
    drive(1'b1, ch, dv, ph);
    chk({nm, "_acc_ready"}, 32'(cfg_if.cfg_ready), 32'd1);
    step();
    drive(1'b0, 3'd0, 16'd0, 16'd0);
    chk_quiet({nm, "_align"});
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    tbl[0] = '{ch: 3'd0, div: 16'd4, phase: 16'd1, d0: 4, p0: 1, d1: 1, p1: 0};
    tbl[1] = '{ch: 3'd1, div: 16'd0, phase: 16'd0, d0: 4, p0: 1, d1: 1, p1: 0};
    tbl[2] = '{ch: 3'd0, div: 16'd4, phase: 16'd7, d0: 4, p0: 3, d1: 1, p1: 0};
    tbl[3] = '{ch: 3'd1, div: 16'd3, phase: 16'd2, d0: 4, p0: 3, d1: 3, p1: 2};
    tbl[4] = '{ch: 3'd1, div: 16'd5, phase: 16'd9, d0: 4, p0: 3, d1: 5, p1: 4};
    tbl[5] = '{ch: 3'd0, div: 16'd1, phase: 16'd5, d0: 1, p0: 0, d1: 5, p1: 4};

    // Reset with a request pending: it must be dropped.
    rst = 1'b1;
    drive(1'b1, 3'd0, 16'd3, 16'd2);
    step();
    step();
    chk_quiet("rst");
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'd0, 16'd0);
    #1;
    chk_quiet("rel_align");
    step();
    run_k("dflt", 0, 20, 1, 0, 1, 0);

    foreach (tbl[r]) begin
      reconfig($sformatf("rec%0d", r), tbl[r].ch, tbl[r].div, tbl[r].phase);
      run_k($sformatf("rec%0d", r), 0, 20, tbl[r].d0, tbl[r].p0, tbl[r].d1, tbl[r].p1);
    end

    // Out-of-range channel: one-cycle error, pattern and lock undisturbed.
    drive(1'b1, 3'd3, 16'd2, 16'd0);
    chk("bad_acc_locked", 32'(locked), 32'd1);
    step();
    drive(1'b0, 3'd0, 16'd0, 16'd0);
    chk("bad_err_pulse", 32'(cfg_if.cfg_err), 32'd1);
    chk("bad_err_locked", 32'(locked), 32'd1);
    chk("bad_err_en", 32'(en_out), 32'(exp_en(21, 1, 0, 5, 4)));
    step();
    chk("bad_err_clear", 32'(cfg_if.cfg_err), 32'd0);
    run_k("bad_after", 22, 6, 1, 0, 5, 4);

    // Request during SETTLE restarts the settle count.
    reconfig("set_a", 3'd0, 16'd2, 16'd1);
    run_k("set_a", 0, 10, 2, 1, 5, 4);
    drive(1'b1, 3'd1, 16'd3, 16'd0);
    chk("set_acc_locked", 32'(locked), 32'd0);
    chk("set_acc_en", 32'(en_out), 32'(exp_en(10, 2, 1, 5, 4)));
    step();
    drive(1'b0, 3'd0, 16'd0, 16'd0);
    chk_quiet("set_align");
    step();
    run_k("set_b", 0, 20, 2, 1, 3, 0);

    // Reset mid-SETTLE with a request: dropped, defaults restored.
    reconfig("rm", 3'd1, 16'd2, 16'd1);
    run_k("rm", 0, 5, 2, 1, 2, 1);
    rst = 1'b1;
    drive(1'b1, 3'd0, 16'd3, 16'd2);
    #1;
    chk_quiet("rm_rst0");
    step();
    chk_quiet("rm_rst1");
    step();
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'd0, 16'd0);
    #1;
    chk_quiet("rm_align");
    step();
    run_k("rm_dflt", 0, 20, 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
